// File: rtl/vx_branch_resolve_tracker_if.sv
// Redirect channel from the branch tracker to the warp scheduler/fetch.
// The master drives the redirect and the slave returns ready.
interface vx_branch_resolve_tracker_if #(
    parameter int NW_WIDTH = 2,
    parameter int XLEN     = 32
);
    logic                valid;
    logic                ready;
    logic [NW_WIDTH-1:0] wid;
    logic [XLEN-1:0]     pc;
    logic                taken;

    modport master (output valid, wid, pc, taken, input ready);
    modport slave  (input valid, wid, pc, taken, output ready);
endinterface

// File: rtl/vx_branch_resolve_tracker.sv
// Per-warp branch tracking (IDLE/PENDING/RESOLVED) with a round-robin registered redirect slot.
// Defining BR_TRACKER_PERF_EN adds taken/not-taken/stall performance counters.
module vx_branch_resolve_tracker #(
    parameter int NUM_WARPS  = 4,
    parameter int NUM_BLOCKS = 1,
    parameter int XLEN       = 32,
    localparam int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         issue_valid,
    input  logic [NW_WIDTH-1:0]          issue_wid,
    input  logic                         issue_is_br,
    input  logic [XLEN-1:0]              issue_pc,
    input  logic [NUM_BLOCKS-1:0]        br_valid,
    input  logic [NUM_BLOCKS*NW_WIDTH-1:0] br_wid,
    input  logic [NUM_BLOCKS-1:0]        br_taken,
    input  logic [NUM_BLOCKS*XLEN-1:0]   br_dest,
    output logic [NUM_WARPS-1:0]         warp_stalled,
    vx_branch_resolve_tracker_if.master  redirect,
    output logic                         br_err
`ifdef BR_TRACKER_PERF_EN
    ,
    output logic [31:0]                  perf_br_taken,
    output logic [31:0]                  perf_br_not_taken,
    output logic [31:0]                  perf_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } br_state_e;

    br_state_e           state   [NUM_WARPS];
    logic [XLEN-1:0]     next_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0] taken_q;

    logic                slot_valid;
    logic [NW_WIDTH-1:0] slot_wid;
    logic [XLEN-1:0]     slot_pc;
    logic                slot_taken;
    logic [NW_WIDTH-1:0] rr_ptr;
    logic                br_err_q;

    logic [NUM_WARPS-1:0] res_hit;
    logic [NUM_WARPS-1:0] res_taken;
    logic [XLEN-1:0]      res_dest [NUM_WARPS];
    logic                 err_now;
    logic [NUM_WARPS-1:0] cand;
    logic                 grant_any;
    logic [NW_WIDTH-1:0]  grant_wid;
    int                   rr_idx;
    logic                 fire;

    assign fire = slot_valid && redirect.ready;

    // Resolution decode: lowest block wins per warp; duplicates and non-pending hits flag an error.
    always_comb begin
        res_hit   = '0;
        res_taken = '0;
        err_now   = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            res_dest[w] = '0;
        end
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (br_valid[b]) begin
                if (int'(br_wid[b*NW_WIDTH +: NW_WIDTH]) >= NUM_WARPS) begin
                    err_now = 1'b1;
                end
                for (int w = 0; w < NUM_WARPS; w++) begin
                    if (br_wid[b*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)) begin
                        if (state[w] != PENDING || res_hit[w]) begin
                            err_now = 1'b1;
                        end else begin
                            res_hit[w]   = 1'b1;
                            res_taken[w] = br_taken[b];
                            res_dest[w]  = br_dest[b*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
        if (issue_valid) begin
            if (int'(issue_wid) >= NUM_WARPS) begin
                err_now = 1'b1;
            end
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (issue_wid == NW_WIDTH'(w) && state[w] != IDLE) begin
                    err_now = 1'b1;
                end
            end
        end
    end

    // The warp currently in the slot is never a candidate, even on the cycle it fires.
    always_comb begin
        cand      = '0;
        grant_any = 1'b0;
        grant_wid = '0;
        rr_idx    = 0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            cand[w] = (state[w] == RESOLVED) && !(slot_valid && slot_wid == NW_WIDTH'(w));
        end
        for (int i = 0; i < NUM_WARPS; i++) begin
            rr_idx = (int'(rr_ptr) + i) % NUM_WARPS;
            if (!grant_any && cand[rr_idx]) begin
                grant_any = 1'b1;
                grant_wid = NW_WIDTH'(rr_idx);
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_stalled[w] = (state[w] != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                state[w] <= IDLE;
            end
            slot_valid <= 1'b0;
            slot_wid   <= '0;
            slot_pc    <= '0;
            slot_taken <= 1'b0;
            rr_ptr     <= '0;
            br_err_q   <= 1'b0;
        end else begin
            // Issue, resolve and handshake are exclusive per warp since each needs a different state.
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (issue_valid && issue_is_br && issue_wid == NW_WIDTH'(w) && state[w] == IDLE) begin
                    state[w]   <= PENDING;
                    next_pc[w] <= issue_pc + XLEN'(4);
                end else if (res_hit[w]) begin
                    state[w]   <= RESOLVED;
                    taken_q[w] <= res_taken[w];
                    if (res_taken[w]) begin
                        next_pc[w] <= res_dest[w];
                    end
                end else if (fire && slot_wid == NW_WIDTH'(w)) begin
                    state[w] <= IDLE;
                end
            end
            if (!slot_valid || fire) begin
                slot_valid <= grant_any;
                if (grant_any) begin
                    slot_wid   <= grant_wid;
                    slot_pc    <= next_pc[grant_wid];
                    slot_taken <= taken_q[grant_wid];
                    rr_ptr     <= (int'(grant_wid) == NUM_WARPS - 1) ? '0 : grant_wid + 1'b1;
                end
            end
            if (err_now) begin
                br_err_q <= 1'b1;
            end
        end
    end

    assign redirect.valid = slot_valid;
    assign redirect.wid   = slot_wid;
    assign redirect.pc    = slot_pc;
    assign redirect.taken = slot_taken;
    assign br_err         = br_err_q;

`ifdef BR_TRACKER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_taken     <= '0;
            perf_br_not_taken <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (fire && slot_taken) begin
                perf_br_taken <= perf_br_taken + 32'd1;
            end
            if (fire && !slot_taken) begin
                perf_br_not_taken <= perf_br_not_taken + 32'd1;
            end
            if (|warp_stalled) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_branch_resolve_tracker.sv
// Directed bench for vx_branch_resolve_tracker: 4 warps, 2 ALU blocks, 32-bit PC.
module tb_vx_branch_resolve_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [1:0]  issue_wid;
    logic        issue_is_br;
    logic [31:0] issue_pc;
    logic [1:0]  br_valid;
    logic [3:0]  br_wid;
    logic [1:0]  br_taken;
    logic [63:0] br_dest;
    logic [3:0]  warp_stalled;
    logic        br_err;
`ifdef BR_TRACKER_PERF_EN
    logic [31:0] perf_br_taken;
    logic [31:0] perf_br_not_taken;
    logic [31:0] perf_stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vx_branch_resolve_tracker_if #(.NW_WIDTH(2), .XLEN(32)) rif ();

    vx_branch_resolve_tracker #(
        .NUM_WARPS (4),
        .NUM_BLOCKS(2),
        .XLEN      (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_wid   (issue_wid),
        .issue_is_br (issue_is_br),
        .issue_pc    (issue_pc),
        .br_valid    (br_valid),
        .br_wid      (br_wid),
        .br_taken    (br_taken),
        .br_dest     (br_dest),
        .warp_stalled(warp_stalled),
        .redirect    (rif),
        .br_err      (br_err)
`ifdef BR_TRACKER_PERF_EN
        ,
        .perf_br_taken    (perf_br_taken),
        .perf_br_not_taken(perf_br_not_taken),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0;
        issue_wid   = 2'd0;
        issue_is_br = 1'b0;
        issue_pc    = 32'h0;
        br_valid    = 2'b00;
        br_wid      = 4'h0;
        br_taken    = 2'b00;
        br_dest     = 64'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rif.ready = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue_br(input logic [1:0] wid, input logic [31:0] pc);
        issue_valid = 1'b1;
        issue_is_br = 1'b1;
        issue_wid   = wid;
        issue_pc    = pc;
    endtask

    task automatic set_br(input int b, input logic [1:0] wid, input logic tk, input logic [31:0] dest);
        br_valid[b]          = 1'b1;
        br_wid[b*2 +: 2]     = wid;
        br_taken[b]          = tk;
        br_dest[b*32 +: 32]  = dest;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (warp_stalled !== 4'b0000) begin n_fail++; $display("FAIL reset_stalled: got %b want 0000", warp_stalled); end
        n_checks++; if (rif.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rif.valid); end
        n_checks++; if (rif.wid !== 2'd0) begin n_fail++; $display("FAIL reset_wid: got %0d want 0", rif.wid); end
        n_checks++; if (rif.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", rif.pc); end
        n_checks++; if (rif.taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", rif.taken); end
        n_checks++; if (br_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", br_err); end
    endtask

    task automatic test_taken();
        do_reset();
        rif.ready = 1'b1;
        issue_br(2'd2, 32'h100);
        tick();
        clear_inputs();
        n_checks++; if (warp_stalled !== 4'b0100) begin n_fail++; $display("FAIL tk_stall_issue: got %b want 0100", warp_stalled); end
        tick();
        tick();
        set_br(0, 2'd2, 1'b1, 32'h200);
        tick();
        clear_inputs();
        n_checks++; if (rif.valid !== 1'b0) begin n_fail++; $display("FAIL tk_valid_early: got %b want 0", rif.valid); end
        tick();
        n_checks++; if (rif.valid !== 1'b1) begin n_fail++; $display("FAIL tk_valid: got %b want 1", rif.valid); end
        n_checks++; if (rif.wid !== 2'd2) begin n_fail++; $display("FAIL tk_wid: got %0d want 2", rif.wid); end
        n_checks++; if (rif.pc !== 32'h200) begin n_fail++; $display("FAIL tk_pc: got %h want 00000200", rif.pc); end
        n_checks++; if (rif.taken !== 1'b1) begin n_fail++; $display("FAIL tk_taken: got %b want 1", rif.taken); end
        n_checks++; if (warp_stalled !== 4'b0100) begin n_fail++; $display("FAIL tk_stall_hold: got %b want 0100", warp_stalled); end
        tick();
        n_checks++; if (warp_stalled !== 4'b0000) begin n_fail++; $display("FAIL tk_stall_drop: got %b want 0000", warp_stalled); end
        n_checks++; if (rif.valid !== 1'b0) begin n_fail++; $display("FAIL tk_valid_after: got %b want 0", rif.valid); end
        n_checks++; if (br_err !== 1'b0) begin n_fail++; $display("FAIL tk_err: got %b want 0", br_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        rif.ready = 1'b1;
        issue_br(2'd1, 32'hFFFF_FFFC);
        tick();
        clear_inputs();
        set_br(1, 2'd1, 1'b0, 32'hDEAD_0000);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (rif.valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b want 1", rif.valid); end
        n_checks++; if (rif.wid !== 2'd1) begin n_fail++; $display("FAIL wrap_wid: got %0d want 1", rif.wid); end
        n_checks++; if (rif.pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want 00000000", rif.pc); end
        n_checks++; if (rif.taken !== 1'b0) begin n_fail++; $display("FAIL wrap_taken: got %b want 0", rif.taken); end
        tick();
        n_checks++; if (warp_stalled !== 4'b0000) begin n_fail++; $display("FAIL wrap_stall: got %b want 0000", warp_stalled); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue_br(2'd0, 32'h1000);
        tick();
        issue_br(2'd1, 32'h2000);
        tick();
        issue_br(2'd3, 32'h3000);
        tick();
        clear_inputs();
        set_br(0, 2'd0, 1'b1, 32'hA0);
        set_br(1, 2'd1, 1'b1, 32'hB0);
        tick();
        clear_inputs();
        set_br(0, 2'd3, 1'b0, 32'hC0);
        tick();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rif.valid !== 1'b1 || rif.wid !== 2'd0 || rif.pc !== 32'hA0)
                begin n_fail++; $display("FAIL b2b_hold_%0d: got v=%b wid=%0d pc=%h want v=1 wid=0 pc=000000a0", i, rif.valid, rif.wid, rif.pc); end
            n_checks++; if (warp_stalled !== 4'b1011) begin n_fail++; $display("FAIL b2b_stall_%0d: got %b want 1011", i, warp_stalled); end
            tick();
        end
        rif.ready = 1'b1;
        tick();
        n_checks++; if (rif.valid !== 1'b1 || rif.wid !== 2'd1 || rif.pc !== 32'hB0 || rif.taken !== 1'b1)
            begin n_fail++; $display("FAIL b2b_second: got v=%b wid=%0d pc=%h tk=%b want v=1 wid=1 pc=000000b0 tk=1", rif.valid, rif.wid, rif.pc, rif.taken); end
        n_checks++; if (warp_stalled !== 4'b1010) begin n_fail++; $display("FAIL b2b_stall_a: got %b want 1010", warp_stalled); end
        tick();
        n_checks++; if (rif.valid !== 1'b1 || rif.wid !== 2'd3 || rif.pc !== 32'h3004 || rif.taken !== 1'b0)
            begin n_fail++; $display("FAIL b2b_third: got v=%b wid=%0d pc=%h tk=%b want v=1 wid=3 pc=00003004 tk=0", rif.valid, rif.wid, rif.pc, rif.taken); end
        tick();
        n_checks++; if (rif.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", rif.valid); end
        n_checks++; if (warp_stalled !== 4'b0000) begin n_fail++; $display("FAIL b2b_stall_end: got %b want 0000", warp_stalled); end
    endtask

    task automatic test_rr_rotation();
        do_reset();
        rif.ready = 1'b1;
        issue_br(2'd2, 32'h40);
        tick();
        clear_inputs();
        set_br(0, 2'd2, 1'b0, 32'h0);
        tick();
        clear_inputs();
        tick();
        tick();
        rif.ready = 1'b0;
        issue_br(2'd0, 32'h500);
        tick();
        issue_br(2'd3, 32'h600);
        tick();
        clear_inputs();
        set_br(0, 2'd0, 1'b0, 32'h0);
        set_br(1, 2'd3, 1'b0, 32'h0);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (rif.valid !== 1'b1 || rif.wid !== 2'd3 || rif.pc !== 32'h604)
            begin n_fail++; $display("FAIL rr_first: got v=%b wid=%0d pc=%h want v=1 wid=3 pc=00000604", rif.valid, rif.wid, rif.pc); end
        rif.ready = 1'b1;
        tick();
        n_checks++; if (rif.valid !== 1'b1 || rif.wid !== 2'd0 || rif.pc !== 32'h504)
            begin n_fail++; $display("FAIL rr_second: got v=%b wid=%0d pc=%h want v=1 wid=0 pc=00000504", rif.valid, rif.wid, rif.pc); end
        tick();
    endtask

    task automatic test_multi_block();
        do_reset();
        issue_br(2'd0, 32'h10);
        tick();
        clear_inputs();
        set_br(0, 2'd0, 1'b1, 32'h40);
        set_br(1, 2'd0, 1'b1, 32'h80);
        tick();
        clear_inputs();
        n_checks++; if (br_err !== 1'b1) begin n_fail++; $display("FAIL multi_err: got %b want 1", br_err); end
        tick();
        n_checks++; if (rif.valid !== 1'b1 || rif.pc !== 32'h40)
            begin n_fail++; $display("FAIL multi_pc: got v=%b pc=%h want v=1 pc=00000040", rif.valid, rif.pc); end
        rif.ready = 1'b1;
        tick();
        tick();
        n_checks++; if (br_err !== 1'b1) begin n_fail++; $display("FAIL multi_err_sticky: got %b want 1", br_err); end
    endtask

    task automatic test_errors();
        do_reset();
        set_br(1, 2'd3, 1'b1, 32'h900);
        tick();
        clear_inputs();
        n_checks++; if (br_err !== 1'b1) begin n_fail++; $display("FAIL idle_br_err: got %b want 1", br_err); end
        tick();
        tick();
        n_checks++; if (rif.valid !== 1'b0 || warp_stalled !== 4'b0000)
            begin n_fail++; $display("FAIL idle_br_nochange: got v=%b stall=%b want v=0 stall=0000", rif.valid, warp_stalled); end
        do_reset();
        issue_br(2'd0, 32'h500);
        tick();
        n_checks++; if (br_err !== 1'b0) begin n_fail++; $display("FAIL reissue_pre: got %b want 0", br_err); end
        issue_br(2'd0, 32'h900);
        tick();
        clear_inputs();
        n_checks++; if (br_err !== 1'b1) begin n_fail++; $display("FAIL reissue_err: got %b want 1", br_err); end
        n_checks++; if (warp_stalled !== 4'b0001) begin n_fail++; $display("FAIL reissue_stall: got %b want 0001", warp_stalled); end
        set_br(0, 2'd0, 1'b0, 32'h0);
        tick();
        clear_inputs();
        tick();
        n_checks++; if (rif.valid !== 1'b1 || rif.pc !== 32'h504)
            begin n_fail++; $display("FAIL reissue_pc: got v=%b pc=%h want v=1 pc=00000504", rif.valid, rif.pc); end
        rif.ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_br(2'd1, 32'h300);
        tick();
        issue_br(2'd2, 32'h400);
        set_br(0, 2'd1, 1'b1, 32'h700);
        tick();
        clear_inputs();
        set_br(0, 2'd3, 1'b0, 32'h0);
        tick();
        clear_inputs();
        n_checks++; if (rif.valid !== 1'b1 || rif.wid !== 2'd1 || rif.pc !== 32'h700 || br_err !== 1'b1)
            begin n_fail++; $display("FAIL rmid_pre: got v=%b wid=%0d pc=%h err=%b want v=1 wid=1 pc=00000700 err=1", rif.valid, rif.wid, rif.pc, br_err); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (warp_stalled !== 4'b0000 || rif.valid !== 1'b0 || rif.wid !== 2'd0 || rif.pc !== 32'h0 || rif.taken !== 1'b0 || br_err !== 1'b0)
            begin n_fail++; $display("FAIL rmid_outputs: got stall=%b v=%b wid=%0d pc=%h tk=%b err=%b want all 0", warp_stalled, rif.valid, rif.wid, rif.pc, rif.taken, br_err); end
        set_br(0, 2'd2, 1'b1, 32'h800);
        tick();
        clear_inputs();
        n_checks++; if (br_err !== 1'b1) begin n_fail++; $display("FAIL rmid_late_err: got %b want 1", br_err); end
        tick();
        tick();
        n_checks++; if (rif.valid !== 1'b0 || warp_stalled !== 4'b0000)
            begin n_fail++; $display("FAIL rmid_noredirect: got v=%b stall=%b want v=0 stall=0000", rif.valid, warp_stalled); end
    endtask

    initial begin
        reset = 1'b1;
        rif.ready = 1'b0;
        clear_inputs();
        test_reset();
        test_taken();
        test_wrap();
        test_back_to_back();
        test_rr_rotation();
        test_multi_block();
        test_errors();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
